// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and helpers for the CPU run controller.
package cpu_run_ctrl_pkg;

   // Run-controller states. The encoding is visible on the state output port.
   typedef enum logic [1:0] {
      RC_HALT  = 2'd0,
      RC_RUN   = 2'd1,
      RC_STEP  = 2'd2,
      RC_BREAK = 2'd3
   } rc_state_e;

   localparam int RC_STATE_W = 2;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_debounce.sv
// Step-button conditioner: two-flop synchroniser, stability counter and
// rising-edge detector. Emits a single-cycle step_req per accepted press.
module cpu_run_ctrl_debounce
   import cpu_run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic step_req
);

   localparam int CW = cnt_width(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          accept;

   // The synchronised level must disagree with the accepted level for
   // DEBOUNCE_CYC consecutive cycles before it is taken as the new level.
   assign differ = (sync2 != stable);
   assign accept = differ && (cnt == CNT_LAST);

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Count consecutive cycles of disagreement; any agreement restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!differ || accept) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Track the accepted level and pulse once when it rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable   <= 1'b0;
         step_req <= 1'b0;
      end else begin
         step_req <= accept && sync2;
         if (accept) begin
            stable <= sync2;
         end
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU clock-enable and debug run controller. Produces one-cycle CPU and timer
// enables from the system clock and arbitrates run / halt / step / breakpoint.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_HZ      = 20_000,
   parameter int TIMER_HZ     = 60,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int ADDR_W       = 12,
   parameter int STEP_W       = 8,
   parameter int TIMER_FREEZE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_sw,
   input  logic                  step_btn,
   input  logic [STEP_W-1:0]     step_n,
   input  logic                  bp_en,
   input  logic [ADDR_W-1:0]     bp_addr,
   input  logic [ADDR_W-1:0]     cpu_pc,
   input  logic                  cpu_done,
   output logic                  cpu_en,
   output logic                  timer_tick,
   output logic [RC_STATE_W-1:0] state,
   output logic [STEP_W-1:0]     steps_left
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int TDIV = CLK_HZ / TIMER_HZ;
   localparam int TW   = cnt_width(DIV);
   localparam int TTW  = cnt_width(TDIV);
   localparam logic [TW-1:0]  TICK_LAST  = TW'(DIV - 1);
   localparam logic [TTW-1:0] TIMER_LAST = TTW'(TDIV - 1);
   localparam logic           FREE_TIMER = (TIMER_FREEZE == 0);

   logic [TW-1:0]     tick_cnt;
   logic [TTW-1:0]    timer_cnt;
   logic              tick;
   logic              timer_wrap;
   logic              step_req;

   rc_state_e         state_q;
   rc_state_e         state_d;
   logic [STEP_W-1:0] steps_q;
   logic [STEP_W-1:0] steps_d;
   logic [STEP_W-1:0] burst_len;
   logic              exempt_q;
   logic              exempt_d;
   logic              run_prev;
   logic              run_rise;
   logic              bp_hit;
   logic              active_d;
   logic              run_d;

   assign tick       = (tick_cnt == TICK_LAST);
   assign timer_wrap = (timer_cnt == TIMER_LAST);
   assign burst_len  = (step_n == '0) ? STEP_W'(1) : step_n;
   assign run_rise   = run_sw && !run_prev;
   assign bp_hit     = bp_en && cpu_done && (cpu_pc == bp_addr);

   // Enables are gated on the state being entered, so nothing is issued in
   // the first cycle after leaving RUN/STEP.
   assign active_d = (state_d == RC_RUN) || (state_d == RC_STEP);
   assign run_d    = (state_d == RC_RUN);

   assign state      = state_q;
   assign steps_left = steps_q;

   cpu_run_ctrl_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn      (step_btn),
      .step_req (step_req)
   );

   // Next-state and burst bookkeeping; earlier conditions win within each state.
   always_comb begin
      state_d  = state_q;
      steps_d  = steps_q;
      exempt_d = exempt_q;
      case (state_q)
         RC_HALT: begin
            if (run_sw) begin
               state_d = RC_RUN;
            end else if (step_req) begin
               state_d  = RC_STEP;
               steps_d  = burst_len;
               exempt_d = 1'b0;
            end
         end
         RC_RUN: begin
            if (!run_sw) begin
               state_d = RC_HALT;
            end else if (bp_hit) begin
               state_d = RC_BREAK;
            end
         end
         RC_STEP: begin
            if (cpu_done && (steps_q <= STEP_W'(1))) begin
               state_d = RC_HALT;
               steps_d = '0;
            end else if (bp_hit && !exempt_q) begin
               state_d = RC_BREAK;
               steps_d = '0;
            end else if (run_rise) begin
               state_d = RC_RUN;
               steps_d = '0;
            end else if (cpu_done) begin
               steps_d = steps_q - STEP_W'(1);
            end
            if (cpu_done) begin
               exempt_d = 1'b0;
            end
         end
         RC_BREAK: begin
            if (!run_sw) begin
               state_d = RC_HALT;
            end else if (step_req) begin
               state_d  = RC_STEP;
               steps_d  = burst_len;
               exempt_d = 1'b1;
            end
         end
         default: begin
            state_d = RC_HALT;
            steps_d = '0;
         end
      endcase
   end

   // Controller state register, including the run switch history used to
   // detect a rising run request during a burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RC_HALT;
         steps_q  <= '0;
         exempt_q <= 1'b0;
         run_prev <= 1'b0;
      end else begin
         state_q  <= state_d;
         steps_q  <= steps_d;
         exempt_q <= exempt_d;
         run_prev <= run_sw;
      end
   end

   // Free-running CPU and timer dividers, independent of controller state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt  <= '0;
         timer_cnt <= '0;
      end else begin
         tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
         timer_cnt <= timer_wrap ? '0 : timer_cnt + TTW'(1);
      end
   end

   // Registered one-cycle enables; the timer optionally freezes outside RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_en     <= 1'b0;
         timer_tick <= 1'b0;
      end else begin
         cpu_en     <= tick && active_d;
         timer_tick <= timer_wrap && (FREE_TIMER || run_d);
      end
   end

endmodule
